io_input_device: RTL

Memory-mapped responder for the board's KEY and SW inputs. It sits on the processor's data-bus side next to the data memory and the display/LED device. It answers loads and stores issued by the address decoder, and gives software debounced, edge-tracked input state with sticky ready and overrun status. It supersedes the raw KEY/SW sampling path and adds the KCTRL and SCTRL control registers.

---
 rtl/io_dev_pkg.sv | 35 +++
 rtl/io_input_device_if.sv | 19 +
 rtl/io_input_device_sw_debouncer.sv | 53 +++++
 rtl/io_input_device.sv | 110 +++++++++++
 4 files changed

// File: rtl/io_dev_pkg.sv
// ============================================================================
// Module      : io_dev_pkg
// Description : Shared constants and helpers for the KEY/SW input device.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package io_dev_pkg;

  localparam int DBITS = 32;
  localparam int KEY_W = 4;
  localparam int SW_W  = 10;

  localparam logic [DBITS-1:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [DBITS-1:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY_BIT   = 0;
  localparam int CTRL_OVERRUN_BIT = 2;
  localparam int CTRL_IE_BIT      = 8;

  function automatic logic [DBITS-1:0] ctrl_word(input logic ready, input logic ovr,
                                                 input logic ie);
    logic [DBITS-1:0] w;
    w                   = '0;
    w[CTRL_READY_BIT]   = ready;
    w[CTRL_OVERRUN_BIT] = ovr;
    w[CTRL_IE_BIT]      = ie;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_input_device_if.sv
// ============================================================================
// Module      : io_input_device_if
// Description : Data-bus load/store port between address decoder and device.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface io_input_device_if;
  logic [io_dev_pkg::DBITS-1:0] addr;
  logic                         rdEn;
  logic                         wrtEn;
  logic [io_dev_pkg::DBITS-1:0] dataIn;
  logic [io_dev_pkg::DBITS-1:0] dataOut;

  modport master (output addr, rdEn, wrtEn, dataIn, input dataOut);
  modport slave  (input addr, rdEn, wrtEn, dataIn, output dataOut);
endinterface

`default_nettype wire

// File: rtl/io_input_device_sw_debouncer.sv
// ============================================================================
// Module      : sw_debouncer
// Description : 2-FF synchronizer plus stable-count debouncer for switches.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sw_debouncer #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_sw,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_loaded
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1, r_s2, r_prev, r_data;
  logic [CW-1:0]    r_count;
  logic             w_hold;
  logic             w_load;

  // Count only while the synced value is stable and differs from what is published.
  assign w_hold = (r_s2 == r_prev) && (r_s2 != r_data);
  assign w_load = w_hold && (r_count == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (!w_hold || w_load) r_count <= '0;
      else                   r_count <= r_count + CW'(1);
      if (w_load) r_data <= r_s2;
    end
  end

  assign o_data   = r_data;
  assign o_loaded = w_load;

endmodule

`default_nettype wire

// File: rtl/io_input_device.sv
// ============================================================================
// Module      : io_input_device
// Description : Memory-mapped KEY/SW responder with sticky ready/overrun.
//               Optional interrupt enable/output under macro IO_INTR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module io_input_device
  import io_dev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  io_input_device_if.slave      bus,
  input  wire logic [KEY_W-1:0] KEY,
  input  wire logic [SW_W-1:0]  SW,
  output logic                  intr
);

  logic [KEY_W-1:0] r_key_s1, r_key_s2, r_kdata;
  logic [SW_W-1:0]  w_sdata;
  logic             w_sload;
  logic             r_k_ready, r_k_ovr, r_s_ready, r_s_ovr;
  logic             w_k_ie, w_s_ie;
  logic             w_kchg, w_krd, w_srd, w_kwr, w_swr;
  logic             w_unused;

  sw_debouncer #(.WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_debouncer (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_sw     (SW),
    .o_data   (w_sdata),
    .o_loaded (w_sload)
  );

  assign w_kchg   = (r_key_s2 != r_kdata);
  assign w_krd    = bus.rdEn  && (bus.addr == ADDR_KDATA);
  assign w_srd    = bus.rdEn  && (bus.addr == ADDR_SDATA);
  assign w_kwr    = bus.wrtEn && (bus.addr == ADDR_KCTRL);
  assign w_swr    = bus.wrtEn && (bus.addr == ADDR_SCTRL);
  assign w_unused = ^bus.dataIn;

  // Keys are synchronized already inverted so reset (0) means "not pressed".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_s1  <= '0;
      r_key_s2  <= '0;
      r_kdata   <= '0;
      r_k_ready <= 1'b0;
      r_k_ovr   <= 1'b0;
      r_s_ready <= 1'b0;
      r_s_ovr   <= 1'b0;
    end else begin
      r_key_s1 <= ~KEY;
      r_key_s2 <= r_key_s1;
      r_kdata  <= r_key_s2;

      if (w_kchg)     r_k_ready <= 1'b1;
      else if (w_krd) r_k_ready <= 1'b0;
      // A concurrent read consumed the old value, so no overrun is recorded.
      if (w_kchg && r_k_ready && !w_krd)                     r_k_ovr <= 1'b1;
      else if (w_kwr && !bus.dataIn[CTRL_OVERRUN_BIT])       r_k_ovr <= 1'b0;

      if (w_sload)    r_s_ready <= 1'b1;
      else if (w_srd) r_s_ready <= 1'b0;
      if (w_sload && r_s_ready && !w_srd)                    r_s_ovr <= 1'b1;
      else if (w_swr && !bus.dataIn[CTRL_OVERRUN_BIT])       r_s_ovr <= 1'b0;
    end
  end

`ifdef IO_INTR_EN
  logic r_k_ie, r_s_ie, r_intr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k_ie <= 1'b0;
      r_s_ie <= 1'b0;
      r_intr <= 1'b0;
    end else begin
      if (w_kwr) r_k_ie <= bus.dataIn[CTRL_IE_BIT];
      if (w_swr) r_s_ie <= bus.dataIn[CTRL_IE_BIT];
      r_intr <= (r_k_ready & r_k_ie) | (r_s_ready & r_s_ie);
    end
  end

  assign w_k_ie = r_k_ie;
  assign w_s_ie = r_s_ie;
  assign intr   = r_intr;
`else
  assign w_k_ie = 1'b0;
  assign w_s_ie = 1'b0;
  assign intr   = 1'b0;
`endif

  always_comb begin
    bus.dataOut = '0;
    case (bus.addr)
      ADDR_KDATA: bus.dataOut = {{(DBITS-KEY_W){1'b0}}, r_kdata};
      ADDR_SDATA: bus.dataOut = {{(DBITS-SW_W){1'b0}}, w_sdata};
      ADDR_KCTRL: bus.dataOut = ctrl_word(r_k_ready, r_k_ovr, w_k_ie);
      ADDR_SCTRL: bus.dataOut = ctrl_word(r_s_ready, r_s_ovr, w_s_ie);
      default:    bus.dataOut = '0;
    endcase
  end

endmodule

`default_nettype wire
